// File: rtl/custom_matrix_prog_pkg.sv
// Shared types and defaults for the programmable matrix: mode and FSM encodings,
// default geometry and the config channel-select width helper.
package cm_pkg;

    localparam int CM_W_DEF   = 4;
    localparam int CM_NCH_DEF = 2;

    typedef enum logic [1:0] {
        CM_BYPASS = 2'b00,
        CM_LUT    = 2'b01,
        CM_HOLD   = 2'b10,
        CM_CHAIN  = 2'b11
    } cm_mode_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } cm_state_e;

    // A single channel still needs a 1-bit select so the port never collapses to zero width.
    function automatic int cm_ch_bits(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/custom_matrix_prog_if.sv
// Config port of the programmable matrix: valid/ready table-write handshake plus sweep status.
interface custom_matrix_prog_if
    import cm_pkg::*;
#(
    parameter int W   = CM_W_DEF,
    parameter int NCH = CM_NCH_DEF
);
    localparam int CHW = cm_ch_bits(NCH);

    logic           cfg_valid;
    logic           cfg_ready;
    logic           cfg_clr;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_addr;
    logic [W-1:0]   cfg_data;
    logic           busy;

    modport master (
        output cfg_valid, cfg_clr, cfg_ch, cfg_addr, cfg_data,
        input  cfg_ready, busy
    );

    modport slave (
        input  cfg_valid, cfg_clr, cfg_ch, cfg_addr, cfg_data,
        output cfg_ready, busy
    );

endinterface

// File: rtl/custom_matrix_prog_lut_bank.sv
// One channel's 2^W x W flop table: one synchronous write port, two asynchronous
// read ports (direct lookup and chained lookup).
module cm_lut_bank #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [W-1:0] waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic [W-1:0] raddr_a_i,
    output logic [W-1:0] rdata_a_o,
    input  logic [W-1:0] raddr_b_i,
    output logic [W-1:0] rdata_b_o
);

    logic [W-1:0] mem_q [2**W];

    // NOTE: the table has no reset; the identity sweep after reset loads every entry,
    // and leaving it off keeps this a plain register file with no reset fan-out.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads are combinational off the flops, so a same-cycle write is seen one cycle later.
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/custom_matrix_prog.sv
// Programmable NCH-channel code matrix: per-channel writable lookup tables, an identity
// sweep FSM driven by reset or a clear request, and registered outputs.
module custom_matrix_prog
    import cm_pkg::*;
#(
    parameter int W   = CM_W_DEF,
    parameter int NCH = CM_NCH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*W-1:0]     in_data,
    input  logic [1:0]           mode,
    output logic [NCH*W-1:0]     out_data,
    output logic                 out_valid,
    custom_matrix_prog_if.slave  cfg
);

    localparam int CHW = cm_ch_bits(NCH);

    cm_state_e      state_q, state_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           sweep_we;
    logic           cfg_we;
    logic           cfg_rdy;
    logic [W-1:0]   wr_addr;
    logic [W-1:0]   wr_data;

    cm_mode_e       mode_e;
    logic [W-1:0]   rd_direct [NCH];
    logic [W-1:0]   rd_chain  [NCH];
    logic [NCH*W-1:0] out_q, out_d;
    logic           valid_q;

    assign mode_e = cm_mode_e'(mode);

    // NOTE: every output of this block gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sweep_we = 1'b0;
        cfg_we   = 1'b0;
        cfg_rdy  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                sweep_we = 1'b1;
                if (ptr_q == {W{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                cfg_rdy = 1'b1;
                if (cfg.cfg_valid) begin
                    if (cfg.cfg_clr) begin
                        state_d = ST_INIT;
                        ptr_d   = '0;
                    end else begin
                        cfg_we = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign cfg.cfg_ready = cfg_rdy;
    assign cfg.busy      = (state_q == ST_INIT);

    // The sweep owns the write port in INIT; config writes only happen in IDLE.
    assign wr_addr = sweep_we ? ptr_q : cfg.cfg_addr;
    assign wr_data = sweep_we ? ptr_q : cfg.cfg_data;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic         we_c;
        logic [W-1:0] chain_addr;

        // A select of NCH or above matches no bank, so such writes are dropped.
        assign we_c = sweep_we | (cfg_we && (cfg.cfg_ch == CHW'(c)));

        if (c == 0) begin : g_head
            assign chain_addr = in_data[0 +: W];
        end else begin : g_link
            assign chain_addr = rd_direct[c-1];
        end

        cm_lut_bank #(.W(W)) u_bank (
            .clk       (clk),
            .we_i      (we_c),
            .waddr_i   (wr_addr),
            .wdata_i   (wr_data),
            .raddr_a_i (in_data[c*W +: W]),
            .rdata_a_o (rd_direct[c]),
            .raddr_b_i (chain_addr),
            .rdata_b_o (rd_chain[c])
        );
    end

    always_comb begin
        out_d = out_q;
        for (int c = 0; c < NCH; c++) begin
            unique case (mode_e)
                CM_BYPASS: out_d[c*W +: W] = in_data[c*W +: W];
                CM_LUT:    out_d[c*W +: W] = rd_direct[c];
                CM_CHAIN:  out_d[c*W +: W] = rd_chain[c];
                default:   out_d[c*W +: W] = out_q[c*W +: W];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (mode_e != CM_HOLD) begin
            out_q   <= out_d;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign out_data  = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_custom_matrix_prog.sv
// Self-checking bench for custom_matrix_prog: directed scenarios plus random traffic,
// all compared against a table-level reference model.
module tb_custom_matrix_prog;

    localparam int W   = 4;
    localparam int NCH = 2;

    logic           clk;
    logic           rst_n;
    logic [7:0]     in_data;
    logic [1:0]     mode;
    logic [7:0]     out_data;
    logic           out_valid;

    custom_matrix_prog_if #(.W(W), .NCH(NCH)) cfg_if ();

    custom_matrix_prog #(.W(W), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .cfg       (cfg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: table contents, which entries are known, remaining sweep steps.
    logic [3:0] m_t [2][16];
    bit         m_k [2][16];
    logic [7:0] m_out;
    bit   [1:0] m_known;
    logic       m_valid;
    int         m_init;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out   = 8'h00;
        m_known = 2'b11;
        m_valid = 1'b0;
        m_init  = 16;
    endtask

    task automatic model_step();
        logic [7:0] nout;
        bit   [1:0] nk;
        nout = m_out;
        nk   = m_known;
        if (mode != 2'b10) begin
            for (int c = 0; c < 2; c++) begin
                logic [3:0] x;
                logic [3:0] mid;
                x = in_data[c*4 +: 4];
                case (mode)
                    2'b00: begin
                        nout[c*4 +: 4] = x;
                        nk[c]          = 1'b1;
                    end
                    2'b01: begin
                        nout[c*4 +: 4] = m_t[c][x];
                        nk[c]          = m_k[c][x];
                    end
                    default: begin
                        if (c == 0) begin
                            nout[3:0] = m_t[0][x];
                            nk[0]     = m_k[0][x];
                        end else begin
                            mid            = m_t[c-1][in_data[(c-1)*4 +: 4]];
                            nout[c*4 +: 4] = m_t[c][mid];
                            nk[c]          = m_k[c-1][in_data[(c-1)*4 +: 4]] && m_k[c][mid];
                        end
                    end
                endcase
            end
            m_out   = nout;
            m_known = nk;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end

        if (m_init > 0) begin
            for (int c = 0; c < 2; c++) begin
                m_t[c][16 - m_init] = 4'(16 - m_init);
                m_k[c][16 - m_init] = 1'b1;
            end
            m_init--;
        end else if (cfg_if.cfg_valid) begin
            if (cfg_if.cfg_clr) begin
                m_init = 16;
            end else begin
                m_t[cfg_if.cfg_ch][cfg_if.cfg_addr] = cfg_if.cfg_data;
                m_k[cfg_if.cfg_ch][cfg_if.cfg_addr] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] mask;
        mask = {{4{m_known[1]}}, {4{m_known[0]}}};
        check("out_data",  32'(out_data & mask), 32'(m_out & mask));
        check("out_valid", 32'(out_valid),       32'(m_valid));
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_init == 0));
        check("busy",      32'(cfg_if.busy),      32'(m_init != 0));
    endtask

    // Drive one cycle of inputs at a falling edge, step the model at the rising edge,
    // compare at the next falling edge.
    task automatic cyc(input logic [1:0] md, input logic [7:0] din, input logic v,
                       input logic clr, input logic ch, input logic [3:0] a, input logic [3:0] d);
        mode             = md;
        in_data          = din;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_clr   = clr;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_data  = d;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic count_init(output int n);
        n = 0;
        for (int i = 0; i < 40 && !cfg_if.cfg_ready; i++) begin
            cyc(2'b01, 8'($urandom), 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            n++;
        end
    endtask

    int n;

    initial begin
        rst_n            = 1'b0;
        mode             = 2'b00;
        in_data          = 8'h00;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_clr   = 1'b0;
        cfg_if.cfg_ch    = 1'b0;
        cfg_if.cfg_addr  = 4'h0;
        cfg_if.cfg_data  = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);

        check("rst_out_data",  32'(out_data),         32'h00);
        check("rst_out_valid", 32'(out_valid),        32'h0);
        check("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'h0);
        check("rst_busy",      32'(cfg_if.busy),      32'h1);

        rst_n = 1'b1;
        count_init(n);
        check("init_cycles", 32'(n), 32'd16);

        cyc(2'b01, 8'hA5, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("identity_a5", 32'(out_data), 32'hA5);

        cyc(2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC);
        cyc(2'b10, 8'h00, 1'b1, 1'b0, 1'b1, 4'h3, 4'h1);
        cyc(2'b01, 8'h33, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("lut_33", 32'(out_data), 32'h1C);

        cyc(2'b10, 8'h5A, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(2'b10, 8'hC3, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("hold_data",  32'(out_data),  32'h1C);
        check("hold_valid", 32'(out_valid), 32'h0);
        cyc(2'b01, 8'h33, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("unhold_valid", 32'(out_valid), 32'h1);

        cyc(2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 4'h2, 4'h7);
        cyc(2'b10, 8'h00, 1'b1, 1'b0, 1'b1, 4'h7, 4'hE);
        cyc(2'b11, 8'hF2, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("chain_f2", 32'(out_data), 32'hE7);

        cyc(2'b01, 8'h05, 1'b1, 1'b0, 1'b0, 4'h5, 4'h9);
        check("collide_old", 32'(out_data[3:0]), 32'h5);
        cyc(2'b01, 8'h05, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        check("collide_new", 32'(out_data[3:0]), 32'h9);

        cyc(2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        count_init(n);
        check("clr_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            cyc(2'b01, v, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            check("clr_identity", 32'(out_data), 32'(v));
        end

        cyc(2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        repeat (6) cyc(2'b01, 8'($urandom), 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_out_data",  32'(out_data),         32'h00);
        check("midrst_out_valid", 32'(out_valid),        32'h0);
        check("midrst_busy",      32'(cfg_if.busy),      32'h1);
        check("midrst_cfg_ready", 32'(cfg_if.cfg_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_init(n);
        check("midrst_cycles", 32'(n), 32'd16);

        for (int i = 0; i < 500; i++) begin
            cyc(2'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0),
                1'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
